// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: converts single local read/write commands into AXI-Lite transactions
// and returns each completion on a response port. One transaction outstanding at a time.
module axil_cmd_master #(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WR_RESP,
    READ_A,
    READ_D,
    RESP
  } state_t;

  state_t state, state_next;

  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = m_axil_awvalid && m_axil_awready;
  assign w_fire   = m_axil_wvalid && m_axil_wready;
  assign b_fire   = m_axil_bvalid && m_axil_bready;
  assign ar_fire  = m_axil_arvalid && m_axil_arready;
  assign r_fire   = m_axil_rvalid && m_axil_rready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every AXI-side output is decoded from registered state/flags only, so no
  // AXI input can reach an AXI output combinationally.
  always_comb begin
    state_next     = state;
    cmd_ready      = (state == IDLE) && !rst;
    busy           = (state != IDLE);
    rsp_valid      = (state == RESP);
    m_axil_awvalid = (state == WRITE) && !aw_done;
    m_axil_wvalid  = (state == WRITE) && !w_done;
    m_axil_bready  = (state == WR_RESP);
    m_axil_arvalid = (state == READ_A);
    m_axil_rready  = (state == READ_D);
    case (state)
      IDLE:    if (cmd_fire) state_next = cmd_write ? WRITE : READ_A;
      WRITE:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
      WR_RESP: if (b_fire) state_next = RESP;
      READ_A:  if (ar_fire) state_next = READ_D;
      READ_D:  if (r_fire) state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        write_q <= cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (b_fire) begin
        resp_q  <= m_axil_bresp;
        rdata_q <= '0;
      end
      if (r_fire) begin
        resp_q  <= m_axil_rresp;
        rdata_q <= m_axil_rdata;
      end
    end
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_awprot = PROT;
  assign m_axil_arprot = PROT;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master: behavioural memory reference, reactive AXI-Lite slave
// with programmable/random latency, and a decoupled response monitor.
module tb_axil_cmd_master;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .PROT(3'b000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          write;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  rsp_t  sb[$];
  beat_t aw_exp[$], w_exp[$], ar_exp[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  int       d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
  bit       rnd = 1'b0, rnd_rsp = 1'b0, rsp_hold = 1'b0;
  logic [1:0] slv_resp = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int draw(input int d);
    return rnd ? int'($urandom_range(0, 3)) : d;
  endfunction

  // ---------------- reactive AXI-Lite slave + protocol checker ----------------
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_act, w_act, ar_act, aw_got, w_got, b_pend, r_pend, b_hs, r_hs;
    bit aw_hs, w_hs, ar_hs, p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [AW-1:0] p_awaddr, p_araddr, s_addr;
    logic [DW-1:0] p_wdata, s_data, r_data;
    logic [SW-1:0] p_wstrb, s_strb;
    beat_t e;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    {aw_act, w_act, ar_act, aw_got, w_got, b_pend, r_pend, b_hs, r_hs} = '0;
    {p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs} = '0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    s_addr = '0; s_data = '0; s_strb = '0; r_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        {aw_act, w_act, ar_act, aw_got, w_got, b_pend, r_pend, b_hs, r_hs} = '0;
        {p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs} = '0;
        continue;
      end
      if (p_awv && !p_awhs) begin
        chk("awvalid_held", 64'(awvalid), 64'd1);
        chk("awaddr_stable", 64'(awaddr), 64'(p_awaddr));
      end
      if (p_wv && !p_whs) begin
        chk("wvalid_held", 64'(wvalid), 64'd1);
        chk("wdata_stable", wdata, p_wdata);
        chk("wstrb_stable", 64'(wstrb), 64'(p_wstrb));
      end
      if (p_arv && !p_arhs) begin
        chk("arvalid_held", 64'(arvalid), 64'd1);
        chk("araddr_stable", 64'(araddr), 64'(p_araddr));
      end
      if (bready) chk("bready_after_aw_w", 64'(aw_got && w_got), 64'd1);

      if (b_hs) begin bvalid = 0; b_hs = 0; aw_got = 0; w_got = 0; end
      if (b_pend && !bvalid) begin
        if (b_cnt == 0) begin bvalid = 1; bresp = slv_resp; b_pend = 0; end
        else b_cnt--;
      end
      b_hs = bvalid && bready;

      if (r_hs) begin rvalid = 0; r_hs = 0; end
      if (r_pend && !rvalid) begin
        if (r_cnt == 0) begin rvalid = 1; rdata = r_data; rresp = slv_resp; r_pend = 0; end
        else r_cnt--;
      end
      r_hs = rvalid && rready;

      awready = 0; aw_hs = 0;
      if (awvalid) begin
        if (!aw_act) begin aw_act = 1; aw_cnt = draw(d_aw); end
        if (aw_cnt == 0) begin awready = 1; aw_hs = 1; aw_act = 0; end
        else aw_cnt--;
      end
      if (aw_hs) begin
        if (aw_exp.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_aw: AW beat addr 0x%0h, required no beat", awaddr);
        end else begin
          e = aw_exp.pop_front();
          chk("awaddr", 64'(awaddr), 64'(e.addr));
          chk("awprot", 64'(awprot), 64'd0);
        end
        aw_got = 1; s_addr = awaddr;
      end

      wready = 0; w_hs = 0;
      if (wvalid) begin
        if (!w_act) begin w_act = 1; w_cnt = draw(d_w); end
        if (w_cnt == 0) begin wready = 1; w_hs = 1; w_act = 0; end
        else w_cnt--;
      end
      if (w_hs) begin
        if (w_exp.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_w: W beat data 0x%0h, required no beat", wdata);
        end else begin
          e = w_exp.pop_front();
          chk("wdata", wdata, e.data);
          chk("wstrb", 64'(wstrb), 64'(e.strb));
        end
        w_got = 1; s_data = wdata; s_strb = wstrb;
      end
      if ((aw_hs || w_hs) && aw_got && w_got) begin
        if (!slv_mem.exists(s_addr)) slv_mem[s_addr] = '0;
        for (int i = 0; i < SW; i++)
          if (s_strb[i]) slv_mem[s_addr][8*i +: 8] = s_data[8*i +: 8];
        b_pend = 1; b_cnt = draw(d_b);
      end

      arready = 0; ar_hs = 0;
      if (arvalid) begin
        if (!ar_act) begin ar_act = 1; ar_cnt = draw(d_ar); end
        if (ar_cnt == 0) begin arready = 1; ar_hs = 1; ar_act = 0; end
        else ar_cnt--;
      end
      if (ar_hs) begin
        if (ar_exp.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_ar: AR beat addr 0x%0h, required no beat", araddr);
        end else begin
          e = ar_exp.pop_front();
          chk("araddr", 64'(araddr), 64'(e.addr));
          chk("arprot", 64'(arprot), 64'd0);
        end
        r_data = slv_mem.exists(araddr) ? slv_mem[araddr] : '0;
        r_pend = 1; r_cnt = draw(d_r);
      end

      p_awv = awvalid; p_awhs = aw_hs; p_awaddr = awaddr;
      p_wv = wvalid; p_whs = w_hs; p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid; p_arhs = ar_hs; p_araddr = araddr;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    bit p_v, p_hs;
    logic          p_w;
    logic [DW-1:0] p_d;
    logic [1:0]    p_r;
    rsp_t e;
    rsp_ready = 0; p_v = 0; p_hs = 0; p_w = 0; p_d = '0; p_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin rsp_ready = 0; p_v = 0; continue; end
      if (p_v && !p_hs) begin
        chk("rsp_valid_held", 64'(rsp_valid), 64'd1);
        chk("rsp_write_stable", 64'(rsp_write), 64'(p_w));
        chk("rsp_rdata_stable", rsp_rdata, p_d);
        chk("rsp_resp_stable", 64'(rsp_resp), 64'(p_r));
      end
      rsp_ready = rsp_hold ? 1'b0 : (rnd_rsp ? 1'($urandom_range(0, 1)) : 1'b1);
      p_hs = rsp_valid && rsp_ready;
      if (p_hs) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_rsp: rsp write=%0b rdata=0x%0h, required none", rsp_write, rsp_rdata);
        end else begin
          e = sb.pop_front();
          chk("rsp_write", 64'(rsp_write), 64'(e.write));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        end
      end
      p_v = rsp_valid; p_w = rsp_write; p_d = rsp_rdata; p_r = rsp_resp;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    rsp_t e;
    beat_t b;
    logic [DW-1:0] mask, old;
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("FAIL cmd_accept_timeout: cmd_ready=0 after %0d cycles, required 1", n);
      cmd_valid = 0;
      return;
    end
    old = ref_mem.exists(a) ? ref_mem[a] : '0;
    b.addr = a; b.data = d; b.strb = s;
    if (wr) begin
      mask = '0;
      for (int i = 0; i < SW; i++) if (s[i]) mask |= 64'hFF << (8 * i);
      ref_mem[a] = (old & ~mask) | (d & mask);
      e = '{1'b1, 64'h0, slv_resp};
      aw_exp.push_back(b);
      w_exp.push_back(b);
    end else begin
      e = '{1'b0, old, slv_resp};
      ar_exp.push_back(b);
    end
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin @(negedge clk); n++; end
    if (sb.size() != 0 || busy) begin
      errors++; checks++;
      $display("FAIL %s_timeout: %0d rsp outstanding busy=%0b, required 0 and 0", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    chk("rst_rsp_write", 64'(rsp_write), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // zero-wait write then readback
    issue(1'b1, 32'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    chk("t1_awvalid_cycle1", 64'(awvalid), 64'd1);
    chk("t1_wvalid_cycle1", 64'(wvalid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    wait_done("t1_wr");
    issue(1'b0, 32'h10, '0, '0);
    chk("t1_arvalid_cycle1", 64'(arvalid), 64'd1);
    wait_done("t1_rd");

    // AW held off, W completes first
    d_aw = 5;
    issue(1'b1, 32'h20, 64'h1122_3344_5566_7788, 8'h0F);
    wait_done("t2");
    d_aw = 0;
    issue(1'b0, 32'h20, '0, '0);
    wait_done("t2_rd");

    // delayed read data with SLVERR
    issue(1'b1, 32'h18, 64'hCAFE_F00D_5A5A_5A5A, 8'hFF);
    wait_done("t3_wr");
    d_r = 7; slv_resp = 2'b10;
    issue(1'b0, 32'h18, '0, '0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      chk("t3_busy", 64'(busy), 64'd1);
      @(negedge clk); n++;
    end
    wait_done("t3_rd");
    d_r = 0; slv_resp = 2'b00;

    // response backpressure; new command must be refused
    rsp_hold = 1;
    issue(1'b1, 32'h28, 64'h0BAD_C0DE_FACE_0001, 8'hF0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    repeat (10) begin
      cmd_write = 0; cmd_addr = 32'h900; cmd_valid = 1;
      chk("t4_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("t4_rsp_valid_hold", 64'(rsp_valid), 64'd1);
      chk("t4_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    cmd_valid = 0; rsp_hold = 0;
    wait_done("t4");

    // alternating write/read with random backpressure
    rnd = 1; rnd_rsp = 1;
    for (int k = 0; k < 4; k++) begin
      a = 32'h100 + 32'($urandom_range(0, 31)) * 8;
      issue(1'b1, a, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      issue(1'b0, a, '0, '0);
    end
    wait_done("t5");
    rnd = 0; rnd_rsp = 0;

    // reset while AW/W stalled
    d_aw = 20; d_w = 20;
    issue(1'b1, 32'h800, 64'h55, 8'hFF);
    @(negedge clk);
    chk("t6_awvalid_pre", 64'(awvalid), 64'd1);
    rst = 1;
    @(negedge clk);
    chk("t6_awvalid", 64'(awvalid), 64'd0);
    chk("t6_wvalid", 64'(wvalid), 64'd0);
    chk("t6_arvalid", 64'(arvalid), 64'd0);
    chk("t6_bready", 64'(bready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    sb.delete(); aw_exp.delete(); w_exp.delete(); ar_exp.delete();
    rst = 0; d_aw = 0; d_w = 0;
    @(negedge clk);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (5) begin
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    issue(1'b0, 32'h10, '0, '0);
    wait_done("t6_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
